soft_rst_seq: RTL
=================

SOFT_RST_SEQ -- requirements
Module: soft_rst_seq

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 4; number of downstream reset domains (1..8).
REQ-002 SHALL have parameter MIN_ASSERT_CYC, default 16; minimum reset hold after PCIe ack (>=1).
REQ-003 SHALL have parameter STAGGER_CYC, default 4; cycles between successive domain releases (>=1).
REQ-004 SHALL have parameter ACK_TIMEOUT_CYC, default 1024; PCIe ack wait limit (>=2).
REQ-005 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port sw_rst_req  input  1  single-cycle software reset request pulse.
REQ-008 SHALL have port hw_rst_req  input  1  level reset request; holds the sequence while high.
REQ-009 SHALL have port pcie_warm_rst_ack_n  input  1  PCIe warm reset ack, active low, already synchronous to clk.
REQ-010 SHALL have port err_clr  input  1  pulse; clears timeout_err.
REQ-011 SHALL have port pcie_warm_rst_n  output  1  PCIe warm reset, active low.
REQ-012 SHALL have port dom_rst_n  output  NUM_DOMAINS  per-domain reset, active low.
REQ-013 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on sequence completion.
REQ-015 SHALL have port timeout_err  output  1  sticky ack-timeout flag.

Function
REQ-016 SHALL implement states IDLE, WAIT_ACK, HOLD, RELEASE; all outputs registered.
REQ-017 IDLE: on sw_rst_req=1 or hw_rst_req=1 SHALL go WAIT_ACK; pcie_warm_rst_n and all dom_rst_n low from next cycle (latency 1).
REQ-018 WAIT_ACK: on pcie_warm_rst_ack_n=0 SHALL drive pcie_warm_rst_n=1 next cycle, load hold counter with MIN_ASSERT_CYC, go HOLD.
REQ-019 HOLD: counter decrements each cycle; hw_rst_req=1 reloads it; at counter=0 with hw_rst_req=0 SHALL go RELEASE.
REQ-020 RELEASE: dom_rst_n[0] SHALL rise on first RELEASE cycle, dom_rst_n[i] STAGGER_CYC*i cycles later, ascending index order.
REQ-021 On rising of dom_rst_n[NUM_DOMAINS-1] SHALL pulse done for that same cycle and enter IDLE; busy low the following cycle.
REQ-022 hw_rst_req=1 during RELEASE SHALL reassert all dom_rst_n and pcie_warm_rst_n next cycle and go WAIT_ACK (restart).
REQ-023 sw_rst_req while busy=1 SHALL be ignored (no queuing).
REQ-024 Simultaneous sw_rst_req and hw_rst_req in IDLE SHALL behave as a single request.
REQ-025 Counters SHALL be sized clog2 of max parameter value +1; no wrap permitted.
REQ-026 err_clr SHALL clear timeout_err unless a timeout sets it in the same cycle (set wins).

Reset
REQ-027 On reset: state=WAIT_ACK, pcie_warm_rst_n=0, dom_rst_n=all 0, busy=1, done=0, timeout_err=0, counters=0.
REQ-028 After reset deassertion the full sequence SHALL run without any request (power-on sequence).
REQ-029 reset asserted mid-sequence SHALL immediately force the REQ-027 values.

Configuration
REQ-030 Macro SOFT_RST_SEQ_TIMEOUT_EN defined: WAIT_ACK counts cycles; after ACK_TIMEOUT_CYC cycles without ack SHALL set timeout_err and proceed exactly as if acked (REQ-018).
REQ-031 Macro SOFT_RST_SEQ_TIMEOUT_EN undefined: WAIT_ACK waits indefinitely; timeout_err tied 0; no timeout counter logic.

Verification (defaults NUM_DOMAINS=4, MIN_ASSERT_CYC=16, STAGGER_CYC=4)
REQ-032 Power-on: release reset, ack_n low 5 cycles later -> pcie_warm_rst_n rises next cycle; dom_rst_n[0] rises 16 cycles after; [1],[2],[3] at +4,+8,+12; done pulses with [3].
REQ-033 SW request: sw_rst_req pulse in IDLE, ack after 3 cycles -> outputs low at +1, same release timing as REQ-032, single done pulse.
REQ-034 HW hold: hw_rst_req high 40 cycles across HOLD -> dom_rst_n[0] rises 16 cycles after hw_rst_req falls.
REQ-035 Restart: hw_rst_req pulse after dom_rst_n[1] released -> all dom_rst_n low next cycle, state WAIT_ACK, no done.
REQ-036 Timeout (macro on): ack never asserted -> timeout_err=1 after 1024 cycles, sequence completes; err_clr pulse -> timeout_err=0 next cycle.
REQ-037 Async reset asserted during RELEASE -> all dom_rst_n and pcie_warm_rst_n low without clock edge, busy=1.

Source files
------------

// File: rtl/soft_rst_seq.sv
// +-----------------------------------------------------------------------------+
// | soft_rst_seq : PCIe warm-reset handshake followed by staggered domain release|
// | Optional ack timeout enabled by macro SOFT_RST_SEQ_TIMEOUT_EN               |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module soft_rst_seq #(
  parameter int NUM_DOMAINS     = 4,
  parameter int MIN_ASSERT_CYC  = 16,
  parameter int STAGGER_CYC     = 4,
  parameter int ACK_TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sw_rst_req,
  input  logic                   hw_rst_req,
  input  logic                   pcie_warm_rst_ack_n,
  input  logic                   err_clr,
  output logic                   pcie_warm_rst_n,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err
);

  localparam logic [1:0] C_IDLE     = 2'd0;
  localparam logic [1:0] C_WAIT_ACK = 2'd1;
  localparam logic [1:0] C_HOLD     = 2'd2;
  localparam logic [1:0] C_RELEASE  = 2'd3;

  localparam int C_HOLD_W = $clog2(MIN_ASSERT_CYC + 1);
  localparam int C_STG_W  = $clog2(STAGGER_CYC + 1);

  logic [1:0]             state_q, state_d;
  logic [C_HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [C_STG_W-1:0]     stag_cnt_q, stag_cnt_d;
  logic                   pcie_rst_n_q, pcie_rst_n_d;
  logic [NUM_DOMAINS-1:0] dom_rst_n_q, dom_rst_n_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   req;
  logic                   ack_ev;
  logic                   ack_to;
  logic                   hold_last;
  logic                   stag_step;
  logic [NUM_DOMAINS-1:0] dom_shift;
  logic                   last_dom;

  // Domains release from index 0 upward by shifting ones in from the bottom
  always_comb begin
    req       = sw_rst_req | hw_rst_req;
    ack_ev    = ~pcie_warm_rst_ack_n | ack_to;
    hold_last = (hold_cnt_q == C_HOLD_W'(1));
    stag_step = (stag_cnt_q == C_STG_W'(1));
    dom_shift = (dom_rst_n_q << 1) | NUM_DOMAINS'(1);
    last_dom  = dom_shift[NUM_DOMAINS-1] & ~dom_rst_n_q[NUM_DOMAINS-1];
  end

`ifdef SOFT_RST_SEQ_TIMEOUT_EN
  localparam int C_TO_W = $clog2(ACK_TIMEOUT_CYC + 1);

  logic [C_TO_W-1:0] to_cnt_q, to_cnt_d;
  logic              to_err_q, to_err_d;

  // Expiry on the last permitted WAIT_ACK cycle is treated exactly like an ack
  assign ack_to   = (state_q == C_WAIT_ACK) &&
                    (to_cnt_q == C_TO_W'(ACK_TIMEOUT_CYC - 1));
  assign to_cnt_d = ((state_q == C_WAIT_ACK) && pcie_warm_rst_ack_n && !ack_to) ?
                    to_cnt_q + C_TO_W'(1) : '0;
  assign to_err_d = (ack_to & pcie_warm_rst_ack_n) | (to_err_q & ~err_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  logic unused_cfg;

  assign ack_to      = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = err_clr ^ (ACK_TIMEOUT_CYC > 1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= C_WAIT_ACK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE: begin
        if (req) state_d = C_WAIT_ACK;
      end
      C_WAIT_ACK: begin
        if (ack_ev) state_d = C_HOLD;
      end
      C_HOLD: begin
        if (hold_last && !hw_rst_req) state_d = C_RELEASE;
      end
      C_RELEASE: begin
        if (hw_rst_req) begin
          state_d = C_WAIT_ACK;
        end else if (done_q) begin
          state_d = C_IDLE;
        end
      end
      default: state_d = C_WAIT_ACK;
    endcase
  end

  always_comb begin
    pcie_rst_n_d = pcie_rst_n_q;
    dom_rst_n_d  = dom_rst_n_q;
    hold_cnt_d   = hold_cnt_q;
    stag_cnt_d   = stag_cnt_q;
    done_d       = 1'b0;
    busy_d       = (state_d != C_IDLE);
    case (state_q)
      C_IDLE: begin
        if (req) begin
          pcie_rst_n_d = 1'b0;
          dom_rst_n_d  = '0;
        end
      end
      C_WAIT_ACK: begin
        if (ack_ev) begin
          pcie_rst_n_d = 1'b1;
          hold_cnt_d   = C_HOLD_W'(MIN_ASSERT_CYC);
        end
      end
      C_HOLD: begin
        if (hw_rst_req) begin
          hold_cnt_d = C_HOLD_W'(MIN_ASSERT_CYC);
        end else if (hold_last) begin
          hold_cnt_d  = '0;
          dom_rst_n_d = NUM_DOMAINS'(1);
          stag_cnt_d  = C_STG_W'(STAGGER_CYC);
          done_d      = (NUM_DOMAINS == 1);
        end else begin
          hold_cnt_d = hold_cnt_q - C_HOLD_W'(1);
        end
      end
      C_RELEASE: begin
        if (hw_rst_req) begin
          pcie_rst_n_d = 1'b0;
          dom_rst_n_d  = '0;
          stag_cnt_d   = '0;
        end else if (!done_q) begin
          if (stag_step) begin
            dom_rst_n_d = dom_shift;
            stag_cnt_d  = C_STG_W'(STAGGER_CYC);
            done_d      = last_dom;
          end else begin
            stag_cnt_d = stag_cnt_q - C_STG_W'(1);
          end
        end
      end
      default: begin
        pcie_rst_n_d = 1'b0;
        dom_rst_n_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcie_rst_n_q <= 1'b0;
      dom_rst_n_q  <= '0;
      hold_cnt_q   <= '0;
      stag_cnt_q   <= '0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      pcie_rst_n_q <= pcie_rst_n_d;
      dom_rst_n_q  <= dom_rst_n_d;
      hold_cnt_q   <= hold_cnt_d;
      stag_cnt_q   <= stag_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign pcie_warm_rst_n = pcie_rst_n_q;
  assign dom_rst_n       = dom_rst_n_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

`default_nettype wire
